// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the unified single-port memory between instruction fetch and load/store.
// Optional watchdog abort is compiled in when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        sel,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

  localparam logic [3:0]  STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

  state_t      state_reg, state_next;
  logic        sel_reg;
  logic [3:0]  streak_reg;
  logic [31:0] if_addr_reg;
  logic        d_we_reg;
  logic [31:0] d_addr_reg;
  logic [31:0] d_wdata_reg;
  logic [3:0]  d_be_reg;
  logic        if_valid_reg, d_valid_reg;
  logic [31:0] if_rdata_reg, d_rdata_reg;

  logic busy;
  logic arb_point;
  logic abort;
  logic done_if, done_d;
  logic abort_if, abort_d;

  assign busy     = (state_reg != IDLE);
  assign done_if  = (state_reg == BUSY_IF) && mem_ack;
  assign done_d   = (state_reg == BUSY_D) && mem_ack;
  assign abort_if = abort && (state_reg == BUSY_IF);
  assign abort_d  = abort && (state_reg == BUSY_D);

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             bus_err_reg;

  // Abort fires on the last BUSY cycle that still sees no ack.
  assign abort   = busy && !mem_ack && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));
  assign bus_err = bus_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_reg <= '0;
      bus_err_reg <= 1'b0;
    end else begin
      bus_err_reg <= abort;
      if (if_gnt || d_gnt) begin
        tmo_cnt_reg <= '0;
      end else if (busy) begin
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
    end
  end
`else
  assign abort   = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    arb_point  = (state_reg == IDLE) || mem_ack;
    if (arb_point) begin
      if (d_req && (!if_req || (streak_reg < STREAK_MAX))) begin
        d_gnt      = 1'b1;
        state_next = BUSY_D;
      end else if (if_req) begin
        if_gnt     = 1'b1;
        state_next = BUSY_IF;
      end else begin
        state_next = IDLE;
      end
    end else if (abort) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      sel_reg      <= 1'b0;
      streak_reg   <= '0;
      if_addr_reg  <= '0;
      d_we_reg     <= 1'b0;
      d_addr_reg   <= '0;
      d_wdata_reg  <= '0;
      d_be_reg     <= '0;
      if_valid_reg <= 1'b0;
      d_valid_reg  <= 1'b0;
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      if_valid_reg <= done_if || abort_if;
      d_valid_reg  <= done_d || abort_d;

      if (done_if) begin
        if_rdata_reg <= mem_rdata;
      end else if (abort_if) begin
        if_rdata_reg <= NOP_INSN;
      end

      // Stores complete without touching the load data register.
      if (done_d && !d_we_reg) begin
        d_rdata_reg <= mem_rdata;
      end else if (abort_d) begin
        d_rdata_reg <= NOP_INSN;
      end

      if (if_gnt) begin
        if_addr_reg <= if_addr;
        sel_reg     <= 1'b0;
        streak_reg  <= '0;
      end

      if (d_gnt) begin
        d_we_reg    <= d_we;
        d_addr_reg  <= d_addr;
        d_wdata_reg <= d_wdata;
        d_be_reg    <= d_be;
        sel_reg     <= 1'b1;
        if (if_req) begin
          streak_reg <= (streak_reg == STREAK_MAX) ? STREAK_MAX : streak_reg + 4'd1;
        end else begin
          streak_reg <= '0;
        end
      end
    end
  end

  // Bitwise 2:1 address mux in front of the memory.
  for (genvar gi = 0; gi < 32; gi++) begin : g_addr_mux
    assign mem_addr[gi] = sel_reg ? d_addr_reg[gi] : if_addr_reg[gi];
  end

  assign mem_req   = busy;
  assign mem_we    = sel_reg & d_we_reg;
  assign mem_wdata = sel_reg ? d_wdata_reg : 32'h0;
  assign mem_be    = sel_reg ? d_be_reg : 4'h0;
  assign sel       = sel_reg;
  assign if_valid  = if_valid_reg;
  assign d_valid   = d_valid_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between instruction fetch (IF) and load/store (D) in the RISC-V core.
- Arbitrates between the two requesters and latches the winner's request.
- Drives the select of the 32-bit 2:1 address/data muxes in front of the memory, and runs the req/ack handshake with the memory.
- Routes the returned read data and completion back to the owner.

Parameters:
- MAX_D_STREAK, 4: maximum consecutive D grants while IF is waiting; the next arbitration then goes to IF. Legal range 1..15.
- TIMEOUT_CYCLES, 16: watchdog limit in cycles. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  32  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_valid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  32  fetched instruction
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_be  in  4  byte enables
- d_gnt  out  1  data request accepted this cycle
- d_valid  out  1  one-cycle pulse; load data valid or store done
- d_rdata  out  32  load data
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_be  out  4  memory byte enables
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle
- mem_rdata  in  32  memory read data
- sel  out  1  mux select: 0 = IF, 1 = D
- bus_err  out  1  timeout abort pulse; tied 0 when ARB_TIMEOUT_EN is undefined

Behaviour:
- Reset (async, rst=1): state IDLE. Outputs zero: gnt, valid, rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be, sel, bus_err. Streak counter and latched request registers cleared.
- Reset mid-transaction: the access is dropped and mem_req falls immediately. No valid is generated for the dropped access.
- FSM states: IDLE, BUSY_IF, BUSY_D.
- Arbitration point: any IDLE cycle, and any BUSY cycle with mem_ack=1 (back-to-back grant, no bubble).
- Winner at an arbitration point:
  - D wins if d_req and (!if_req or streak < MAX_D_STREAK).
  - Otherwise IF wins if if_req.
  - Otherwise go to IDLE.
- Grant signalling: if_gnt/d_gnt are combinational, asserted in the arbitration cycle; at most one is high per cycle. The granted request fields are captured on that clock edge.
- Next state: BUSY_IF or BUSY_D. sel is registered and updated on the same edge (0 for IF, 1 for D).
- mem_addr/mem_wdata/mem_be/mem_we are the latched D fields when sel=1 and the latched IF fields when sel=0. The address path uses the team's 32-bit 2:1 mux. mem_we is forced 0 for IF.
- In BUSY_*: mem_req=1, and all mem_* outputs stay stable until mem_ack.
- On mem_ack:
  - mem_rdata is registered into the owner's rdata.
  - The owner's valid pulses in the next cycle; rdata holds until the next completion for that owner.
  - Store completion: d_valid pulses, d_rdata is unchanged.
- Latency: grant at cycle N, mem_req from N+1. If ack arrives at N+1, valid at N+2. Peak throughput is one access per cycle while ack returns at 1 cycle.
- Streak counter, updated on grants only:
  - D grant with if_req=1: increment, saturating at MAX_D_STREAK.
  - D grant with if_req=0: clear.
  - IF grant: clear.
- Request inputs are ignored outside arbitration cycles. A requester deasserting req before its gnt is legal; no grant is issued.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A counter runs in BUSY_*, cleared on each new grant.
  - If it reaches TIMEOUT_CYCLES without mem_ack: mem_req drops, bus_err and the owner's valid pulse together in the next cycle, owner rdata becomes 32'h0000_0013 (NOP), state returns to IDLE.
  - A mem_ack arriving in the abort cycle is ignored.
- ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; bus_err is constant 0.

Test Plan:
- Reset, then if_req with if_addr=0x100, memory acks after 1 cycle with 0x00500093 -> if_gnt at N, mem_req and sel=0 at N+1, if_valid at N+2 with if_rdata=0x00500093.
- Same-cycle if_req and d_req (store to 0x2000, d_wdata=0xDEADBEEF, d_be=4'b0011) -> d_gnt first with mem_we=1, mem_be=0011 and sel=1; if_gnt on the ack cycle with no idle gap.
- d_req and if_req both held continuously, MAX_D_STREAK=4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
- Memory holds ack low for 5 cycles -> mem_req, mem_addr and sel stable for all 5 cycles; exactly one valid pulse.
- rst raised while BUSY_D is waiting for ack -> mem_req=0 and all outputs 0 immediately; after release, a new if_req is serviced normally.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and memory never acking -> bus_err and d_valid pulse after 16 BUSY cycles, d_rdata=0x00000013, return to IDLE.
